// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 800x600@72 timing, colour types and width helpers.
package vga_pkg;

  localparam int DEF_HVA     = 800;
  localparam int DEF_HFP     = 56;
  localparam int DEF_HP      = 120;
  localparam int DEF_HBP     = 64;
  localparam int DEF_VVA     = 600;
  localparam int DEF_VFP     = 37;
  localparam int DEF_VP      = 6;
  localparam int DEF_VBP     = 23;
  localparam int DEF_COLOR_W = 4;
  localparam int DEF_BOX     = 32;
  localparam int DEF_STEP    = 2;

  // Pixel at the default colour depth; pattern sources with other depths
  // declare the same {r,g,b} layout at their own width.
  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  localparam rgb_t DEF_FG = '{r: '0, g: '1, b: '0};
  localparam rgb_t DEF_BG = '{r: '0, g: '0, b: '0};

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  // Register width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters with sync, visible and frame-boundary flags.
// Flags describe the current counter position; callers register them.
module vga_timing import vga_pkg::*; #(
  parameter int HVA = DEF_HVA,
  parameter int HFP = DEF_HFP,
  parameter int HP  = DEF_HP,
  parameter int HBP = DEF_HBP,
  parameter int VVA = DEF_VVA,
  parameter int VFP = DEF_VFP,
  parameter int VP  = DEF_VP,
  parameter int VBP = DEF_VBP,
  localparam int H_TOT = HVA + HFP + HP + HBP,
  localparam int V_TOT = VVA + VFP + VP + VBP,
  localparam int HW    = cnt_w(H_TOT),
  localparam int VW    = cnt_w(V_TOT)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_h_pulse,
  output logic          o_v_pulse,
  output logic          o_visible,
  output logic          o_frame_start,
  output logic          o_frame_end
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  // Advance the raster position while enabled; hold it otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  // Compared as int so a pulse ending exactly at the total cannot wrap.
  assign o_h_pulse     = (int'(r_h_cnt) >= HVA + HFP) && (int'(r_h_cnt) < HVA + HFP + HP);
  assign o_v_pulse     = (int'(r_v_cnt) >= VVA + VFP) && (int'(r_v_cnt) < VVA + VFP + VP);
  assign o_visible     = (int'(r_h_cnt) < HVA) && (int'(r_v_cnt) < VVA);
  assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_frame_end   = w_h_last && w_v_last;
  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;

endmodule

// File: rtl/vga_bounce_gen.sv
// VGA pattern source: background fill with a box that bounces once per frame.
// Every output is registered, so it trails the raster counters by one cycle.
module vga_bounce_gen import vga_pkg::*; #(
  parameter int HVA     = DEF_HVA,
  parameter int HFP     = DEF_HFP,
  parameter int HP      = DEF_HP,
  parameter int HBP     = DEF_HBP,
  parameter int VVA     = DEF_VVA,
  parameter int VFP     = DEF_VFP,
  parameter int VP      = DEF_VP,
  parameter int VBP     = DEF_VBP,
  parameter bit HS_POL  = 1'b1,
  parameter bit VS_POL  = 1'b1,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int BOX     = DEF_BOX,
  parameter int STEP    = DEF_STEP,
  parameter logic [3*COLOR_W-1:0] FG = {{COLOR_W{1'b0}}, {COLOR_W{1'b1}}, {COLOR_W{1'b0}}},
  parameter logic [3*COLOR_W-1:0] BG = (3*COLOR_W)'(DEF_BG)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  output logic               o_h_sync,
  output logic               o_v_sync,
  output logic [COLOR_W-1:0] o_red,
  output logic [COLOR_W-1:0] o_green,
  output logic [COLOR_W-1:0] o_blue,
  output logic               o_de,
  output logic               o_frame_start
);

  localparam int H_TOT = HVA + HFP + HP + HBP;
  localparam int V_TOT = VVA + VFP + VP + VBP;
  localparam int HW    = cnt_w(H_TOT);
  localparam int VW    = cnt_w(V_TOT);
  localparam int XW    = cnt_w(HVA);
  localparam int YW    = cnt_w(VVA);

  // Sprite arithmetic carries one extra bit so pos+STEP never wraps.
  localparam logic [XW:0]   X_LIM_E  = (XW+1)'(HVA - BOX);
  localparam logic [YW:0]   Y_LIM_E  = (YW+1)'(VVA - BOX);
  localparam logic [XW:0]   X_STEP_E = (XW+1)'(STEP);
  localparam logic [YW:0]   Y_STEP_E = (YW+1)'(STEP);
  localparam logic [XW-1:0] X_STEP   = XW'(STEP);
  localparam logic [YW-1:0] Y_STEP   = YW'(STEP);

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pix_t;

  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_h_pulse;
  logic          w_v_pulse;
  logic          w_visible;
  logic          w_frame_start;
  logic          w_frame_end;
  logic          w_in_box;
  logic          w_update;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  dir_t          r_dx;
  dir_t          r_dy;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] w_y_nxt;
  dir_t          w_dx_nxt;
  dir_t          w_dy_nxt;
  logic [XW:0]   w_x_inc;
  logic [YW:0]   w_y_inc;

  pix_t          r_pix;
  logic          r_h_sync;
  logic          r_v_sync;
  logic          r_de;
  logic          r_frame_start;

  vga_timing #(
    .HVA(HVA), .HFP(HFP), .HP(HP), .HBP(HBP),
    .VVA(VVA), .VFP(VFP), .VP(VP), .VBP(VBP)
  ) u_timing (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_en),
    .o_h_cnt       (w_h_cnt),
    .o_v_cnt       (w_v_cnt),
    .o_h_pulse     (w_h_pulse),
    .o_v_pulse     (w_v_pulse),
    .o_visible     (w_visible),
    .o_frame_start (w_frame_start),
    .o_frame_end   (w_frame_end)
  );

  // Moving only on the last cycle of a frame keeps the box whole within a frame.
  assign w_update = i_en && w_frame_end;
  assign w_x_inc  = {1'b0, r_x} + X_STEP_E;
  assign w_y_inc  = {1'b0, r_y} + Y_STEP_E;

  // Sprite state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_dx <= DIR_POS;
      r_dy <= DIR_POS;
    end else begin
      r_x  <= w_x_nxt;
      r_y  <= w_y_nxt;
      r_dx <= w_dx_nxt;
      r_dy <= w_dy_nxt;
    end
  end

  // Per-axis step with clamp-and-reflect at either wall; axes are independent.
  always_comb begin
    w_x_nxt  = r_x;
    w_y_nxt  = r_y;
    w_dx_nxt = r_dx;
    w_dy_nxt = r_dy;
    if (w_update) begin
      if (r_dx == DIR_POS) begin
        if (w_x_inc >= X_LIM_E) begin
          w_x_nxt  = X_LIM_E[XW-1:0];
          w_dx_nxt = DIR_NEG;
        end else begin
          w_x_nxt  = w_x_inc[XW-1:0];
        end
      end else begin
        if ({1'b0, r_x} <= X_STEP_E) begin
          w_x_nxt  = '0;
          w_dx_nxt = DIR_POS;
        end else begin
          w_x_nxt  = r_x - X_STEP;
        end
      end
      if (r_dy == DIR_POS) begin
        if (w_y_inc >= Y_LIM_E) begin
          w_y_nxt  = Y_LIM_E[YW-1:0];
          w_dy_nxt = DIR_NEG;
        end else begin
          w_y_nxt  = w_y_inc[YW-1:0];
        end
      end else begin
        if ({1'b0, r_y} <= Y_STEP_E) begin
          w_y_nxt  = '0;
          w_dy_nxt = DIR_POS;
        end else begin
          w_y_nxt  = r_y - Y_STEP;
        end
      end
    end
  end

  assign w_in_box = (int'(w_h_cnt) >= int'(r_x)) && (int'(w_h_cnt) < int'(r_x) + BOX) &&
                    (int'(w_v_cnt) >= int'(r_y)) && (int'(w_v_cnt) < int'(r_y) + BOX);

  // Output register: colour mux and syncs, blanked while disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pix         <= '0;
      r_h_sync      <= ~HS_POL;
      r_v_sync      <= ~VS_POL;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (!i_en) begin
      r_pix         <= '0;
      r_h_sync      <= ~HS_POL;
      r_v_sync      <= ~VS_POL;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix         <= w_visible ? (w_in_box ? pix_t'(FG) : pix_t'(BG)) : '0;
      r_h_sync      <= w_h_pulse ? HS_POL : ~HS_POL;
      r_v_sync      <= w_v_pulse ? VS_POL : ~VS_POL;
      r_de          <= w_visible;
      r_frame_start <= w_frame_start;
    end
  end

  assign o_red         = r_pix.r;
  assign o_green       = r_pix.g;
  assign o_blue        = r_pix.b;
  assign o_h_sync      = r_h_sync;
  assign o_v_sync      = r_v_sync;
  assign o_de          = r_de;
  assign o_frame_start = r_frame_start;

endmodule
